// File: rtl/img_sprite_mover.sv
// img_sprite_mover
// Overlays an IMG_H x IMG_V image, fetched from an external ROM, onto the
// TFT_H x TFT_V active area. The image is moved on a periodic tick, and each
// move is applied only at frame start so that a frame never tears.
//
// Ports
//   clk50M     in   system clock
//   rst        in   asynchronous active-high reset
//   tft_de     in   active-area enable from the timing generator
//   hcnt/vcnt  in   active-area column / row (10 bits)
//   mode       in   0 HOLD, 1 TOUR, 2 BOUNCE, 3 HOLD
//   pause      in   freezes the move tick counter
//   rom_addr   out  image ROM address (combinational from the counter)
//   rom_q      in   ROM data, ROM_LAT cycles after rom_addr
//   data_in    out  pixel to the TFT, ROM_LAT+1 cycles after hcnt/vcnt
//   img_hbegin out  current top-left x
//   img_vbegin out  current top-left y
//   move_ack   out  one-cycle pulse when a position update is applied
`timescale 1ns/1ps
module img_sprite_mover #(
  parameter int             IMG_H       = 120,
  parameter int             IMG_V       = 120,
  parameter int             TFT_H       = 480,
  parameter int             TFT_V       = 272,
  parameter int             ADDR_W      = 15,
  parameter int             PIX_W       = 16,
  parameter int             ROM_LAT     = 1,
  parameter int             TICK_CYCLES = 25000000,
  parameter int             STEP_X      = 8,
  parameter int             STEP_Y      = 4,
  parameter logic [PIX_W-1:0] BG_COLOR  = 16'h0000
) (
  input  logic              clk50M,
  input  logic              rst,
  input  logic              tft_de,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic [1:0]        mode,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_q,
  output logic [PIX_W-1:0]  data_in,
  output logic [9:0]        img_hbegin,
  output logic [9:0]        img_vbegin,
  output logic              move_ack
);

  localparam int COLS   = TFT_H / IMG_H;
  localparam int ROWS   = TFT_V / IMG_V;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(IMG_H * IMG_V - 1);

  localparam logic signed [11:0] STEP_X_S = 12'(STEP_X);
  localparam logic signed [11:0] STEP_Y_S = 12'(STEP_Y);
  localparam logic signed [11:0] XLIM_S   = 12'(TFT_H - IMG_H);
  localparam logic signed [11:0] YLIM_S   = 12'(TFT_V - IMG_V);

  // One bounce step on one axis. Returns {dir_neg, new_pos}; the position is
  // saturated to [0, lim] and the direction flips on the saturating side.
  function automatic logic [10:0] bounce_step(input logic [9:0]         pos,
                                               input logic               neg,
                                               input logic signed [11:0] step,
                                               input logic signed [11:0] lim);
    logic signed [11:0] nxt;
    nxt = neg ? ($signed({2'b00, pos}) - step) : ($signed({2'b00, pos}) + step);
    if (nxt > lim)
      bounce_step = {1'b1, lim[9:0]};
    else if (nxt < 12'sd0)
      bounce_step = {1'b0, 10'd0};
    else
      bounce_step = {neg, nxt[9:0]};
  endfunction

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              pending_q, pending_d;
  logic [9:0]        hbeg_q, hbeg_d, vbeg_q, vbeg_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic              tour_on_q, tour_on_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, addr_cur, rom_addr_q;
  logic [ROM_LAT-1:0] act_dly_q;
  logic [ROM_LAT:0]  act_chain;
  logic [PIX_W-1:0]  data_q, data_d;

  logic frame_start, tick, apply, img_act;
  logic [10:0] h11, v11, hb11, vb11, bx, by;

  // Stage p0: tick, frame start and position update
  assign frame_start = tft_de && (hcnt == 10'd0) && (vcnt == 10'd0);
  assign tick        = !pause && (tick_cnt_q == TICK_LAST);
  // A tick landing on frame start is consumed immediately rather than queued.
  assign apply       = frame_start && (pending_q || tick);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    pending_d  = pending_q;
    hbeg_d     = hbeg_q;
    vbeg_d     = vbeg_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    tour_on_d  = tour_on_q;
    col_d      = col_q;
    row_d      = row_q;
    ack_d      = 1'b0;
    bx         = bounce_step(hbeg_q, dir_x_q, STEP_X_S, XLIM_S);
    by         = bounce_step(vbeg_q, dir_y_q, STEP_Y_S, YLIM_S);

    if (!pause)
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    if (apply)
      pending_d = 1'b0;
    else if (tick)
      pending_d = 1'b1;

    if (apply) begin
      ack_d = 1'b1;
      case (mode)
        2'd1: begin
          tour_on_d = 1'b1;
          if (!tour_on_q) begin
            // Entering the tour always restarts at tile 0.
            col_d  = '0;
            row_d  = '0;
            hbeg_d = 10'd0;
            vbeg_d = 10'd0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d  = '0;
              hbeg_d = 10'd0;
              vbeg_d = 10'd0;
            end else begin
              // Serpentine: the row change keeps x, only y advances.
              row_d  = row_q + ROW_W'(1);
              vbeg_d = vbeg_q + 10'(IMG_V);
            end
          end else begin
            col_d  = col_q + COL_W'(1);
            hbeg_d = row_q[0] ? (hbeg_q - 10'(IMG_H)) : (hbeg_q + 10'(IMG_H));
          end
        end
        2'd2: begin
          tour_on_d = 1'b0;
          {dir_x_d, hbeg_d} = bx;
          {dir_y_d, vbeg_d} = by;
        end
        default: tour_on_d = 1'b0;
      endcase
    end
  end

  // Stage p0: active window and raster-order ROM address counter
  assign h11  = {1'b0, hcnt};
  assign v11  = {1'b0, vcnt};
  assign hb11 = {1'b0, hbeg_q};
  assign vb11 = {1'b0, vbeg_q};
  assign img_act = tft_de && (h11 >= hb11) && (h11 < hb11 + 11'(IMG_H)) &&
                   (v11 >= vb11) && (v11 < vb11 + 11'(IMG_V));

  assign addr_cur = frame_start ? '0 : addr_cnt_q;

  always_comb begin
    addr_cnt_d = frame_start ? '0 : addr_cnt_q;
    if (img_act)
      addr_cnt_d = (addr_cur == PIX_LAST) ? addr_cur : addr_cur + ADDR_W'(1);
  end

  // The ROM sees the address in the same cycle as hcnt/vcnt; only the
  // held value needs a register.
  assign rom_addr = img_act ? addr_cur : rom_addr_q;

  // Stage p1..pROM_LAT: activity follows the ROM pipeline
  assign act_chain[0]         = img_act;
  assign act_chain[ROM_LAT:1] = act_dly_q;

  // Stage pROM_LAT+1: output pixel register
  assign data_d = act_dly_q[ROM_LAT-1] ? rom_q : BG_COLOR;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pending_q  <= 1'b0;
      hbeg_q     <= 10'd0;
      vbeg_q     <= 10'd0;
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      tour_on_q  <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      ack_q      <= 1'b0;
      addr_cnt_q <= '0;
      rom_addr_q <= '0;
      act_dly_q  <= '0;
      data_q     <= BG_COLOR;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      hbeg_q     <= hbeg_d;
      vbeg_q     <= vbeg_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      tour_on_q  <= tour_on_d;
      col_q      <= col_d;
      row_q      <= row_d;
      ack_q      <= ack_d;
      addr_cnt_q <= addr_cnt_d;
      rom_addr_q <= rom_addr;
      act_dly_q  <= act_chain[ROM_LAT-1:0];
      data_q     <= data_d;
    end
  end

  assign img_hbegin = hbeg_q;
  assign img_vbegin = vbeg_q;
  assign move_ack   = ack_q;
  assign data_in    = data_q;

endmodule

// File: tb/tb_img_sprite_mover.sv
`timescale 1ns/1ps
module tb_img_sprite_mover;
  localparam logic [15:0] BG = 16'hBEEF;

  logic        clk50M = 1'b0;
  logic        rst, tft_de, pause, move_ack;
  logic [9:0]  hcnt, vcnt, img_hbegin, img_vbegin;
  logic [1:0]  mode;
  logic [14:0] rom_addr, rom_p1, rom_p2;
  logic [15:0] rom_q, data_in;
  int compared = 0;
  int mismatched = 0;

  img_sprite_mover #(
    .IMG_H(120), .IMG_V(120), .TFT_H(480), .TFT_V(272), .ADDR_W(15), .PIX_W(16),
    .ROM_LAT(2), .TICK_CYCLES(4), .STEP_X(100), .STEP_Y(4), .BG_COLOR(BG)
  ) dut (
    .clk50M(clk50M), .rst(rst), .tft_de(tft_de), .hcnt(hcnt), .vcnt(vcnt),
    .mode(mode), .pause(pause), .rom_addr(rom_addr), .rom_q(rom_q),
    .data_in(data_in), .img_hbegin(img_hbegin), .img_vbegin(img_vbegin),
    .move_ack(move_ack)
  );

  always #5 clk50M = ~clk50M;

  // ROM model: two-cycle latency, contents equal to the address.
  always @(posedge clk50M) begin
    rom_p1 <= rom_addr;
    rom_p2 <= rom_p1;
  end
  assign rom_q = {1'b0, rom_p2};

  task automatic step();
    @(posedge clk50M);
    #1;
  endtask

  task automatic idle(input int n);
    tft_de = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_frame();
    tft_de = 1'b1; hcnt = 10'd0; vcnt = 10'd0;
    step();
    tft_de = 1'b0;
  endtask

  task automatic reset_dut();
    tft_de = 1'b0; hcnt = 10'd0; vcnt = 10'd0; pause = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2'd0;
    reset_dut();
    compared++;
    if (img_hbegin !== 10'd0 || img_vbegin !== 10'd0) begin
      mismatched++;
      $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", img_hbegin, img_vbegin);
    end
    compared++;
    if (rom_addr !== 15'd0) begin
      mismatched++;
      $display("FAIL reset_rom_addr: got %0d want 0", rom_addr);
    end
    compared++;
    if (data_in !== BG) begin
      mismatched++;
      $display("FAIL reset_data_in: got %h want %h", data_in, BG);
    end
    compared++;
    if (move_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_move_ack: got %b want 0", move_ack);
    end
  endtask

  task automatic test_tour();
    int eh[9];
    int ev[9];
    eh = '{0, 120, 240, 360, 360, 240, 120, 0, 0};
    ev = '{0, 0, 0, 0, 120, 120, 120, 120, 0};
    mode = 2'd1;
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      idle(6);
      do_frame();
      compared++;
      if (move_ack !== 1'b1 || img_hbegin !== 10'(eh[i]) || img_vbegin !== 10'(ev[i])) begin
        mismatched++;
        $display("FAIL tour_%0d: got ack=%b pos=(%0d,%0d) want ack=1 pos=(%0d,%0d)",
                 i, move_ack, img_hbegin, img_vbegin, eh[i], ev[i]);
      end
    end
  endtask

  task automatic test_bounce();
    int ex[8];
    ex = '{100, 200, 300, 360, 260, 160, 60, 0};
    mode = 2'd2;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      idle(6);
      do_frame();
      compared++;
      if (move_ack !== 1'b1 || img_hbegin !== 10'(ex[i]) || img_vbegin !== 10'(4 * (i + 1))) begin
        mismatched++;
        $display("FAIL bounce_%0d: got ack=%b pos=(%0d,%0d) want ack=1 pos=(%0d,%0d)",
                 i, move_ack, img_hbegin, img_vbegin, ex[i], 4 * (i + 1));
      end
    end
  endtask

  task automatic test_mode_switch();
    // Continues from the bounce end position (0,32).
    mode = 2'd1;
    idle(6);
    do_frame();
    compared++;
    if (move_ack !== 1'b1 || img_hbegin !== 10'd0 || img_vbegin !== 10'd0) begin
      mismatched++;
      $display("FAIL tour_entry: got ack=%b pos=(%0d,%0d) want ack=1 pos=(0,0)",
               move_ack, img_hbegin, img_vbegin);
    end
    idle(6);
    do_frame();
    compared++;
    if (img_hbegin !== 10'd120 || img_vbegin !== 10'd0) begin
      mismatched++;
      $display("FAIL tour_after_entry: got (%0d,%0d) want (120,0)", img_hbegin, img_vbegin);
    end
    mode = 2'd3;
    idle(6);
    do_frame();
    compared++;
    if (move_ack !== 1'b1 || img_hbegin !== 10'd120 || img_vbegin !== 10'd0) begin
      mismatched++;
      $display("FAIL mode3_hold: got ack=%b pos=(%0d,%0d) want ack=1 pos=(120,0)",
               move_ack, img_hbegin, img_vbegin);
    end
  endtask

  task automatic test_midframe_tick();
    mode = 2'd2;
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      tft_de = 1'b1; hcnt = 10'(10 + i); vcnt = 10'd5;
      step();
      compared++;
      if (move_ack !== 1'b0 || img_hbegin !== 10'd0 || img_vbegin !== 10'd0) begin
        mismatched++;
        $display("FAIL midframe_%0d: got ack=%b pos=(%0d,%0d) want ack=0 pos=(0,0)",
                 i, move_ack, img_hbegin, img_vbegin);
      end
    end
    tft_de = 1'b0;
    do_frame();
    compared++;
    if (move_ack !== 1'b1 || img_hbegin !== 10'd100 || img_vbegin !== 10'd4) begin
      mismatched++;
      $display("FAIL midframe_apply: got ack=%b pos=(%0d,%0d) want ack=1 pos=(100,4)",
               move_ack, img_hbegin, img_vbegin);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'd2;
    reset_dut();
    step(); step(); step();   // tick counter now at its terminal value
    tft_de = 1'b1; hcnt = 10'd0; vcnt = 10'd0;
    step();
    compared++;
    if (move_ack !== 1'b1 || img_hbegin !== 10'd100 || img_vbegin !== 10'd4) begin
      mismatched++;
      $display("FAIL coincident_apply: got ack=%b pos=(%0d,%0d) want ack=1 pos=(100,4)",
               move_ack, img_hbegin, img_vbegin);
    end
    step();                   // second frame start, no tick in between
    tft_de = 1'b0;
    compared++;
    if (move_ack !== 1'b0 || img_hbegin !== 10'd100) begin
      mismatched++;
      $display("FAIL coincident_once: got ack=%b x=%0d want ack=0 x=100", move_ack, img_hbegin);
    end
  endtask

  task automatic test_pause();
    mode = 2'd2;
    reset_dut();
    idle(5);
    pause = 1'b1;
    idle(12);
    do_frame();
    compared++;
    if (move_ack !== 1'b1 || img_hbegin !== 10'd100) begin
      mismatched++;
      $display("FAIL pause_pending: got ack=%b x=%0d want ack=1 x=100", move_ack, img_hbegin);
    end
    idle(12);
    do_frame();
    compared++;
    if (move_ack !== 1'b0 || img_hbegin !== 10'd100) begin
      mismatched++;
      $display("FAIL pause_frozen: got ack=%b x=%0d want ack=0 x=100", move_ack, img_hbegin);
    end
    pause = 1'b0;
    idle(6);
    do_frame();
    compared++;
    if (move_ack !== 1'b1 || img_hbegin !== 10'd200) begin
      mismatched++;
      $display("FAIL pause_resume: got ack=%b x=%0d want ack=1 x=200", move_ack, img_hbegin);
    end
  endtask

  task automatic test_render();
    int q[$];
    int e, want;
    mode = 2'd1;
    reset_dut();
    idle(6); do_frame();
    idle(6); do_frame();
    compared++;
    if (img_hbegin !== 10'd120 || img_vbegin !== 10'd0) begin
      mismatched++;
      $display("FAIL render_setup: got (%0d,%0d) want (120,0)", img_hbegin, img_vbegin);
    end
    mode = 2'd0;
    idle(6);
    tft_de = 1'b1; hcnt = 10'd0; vcnt = 10'd0;
    q.push_back(int'(BG));
    step();
    for (int v = 0; v < 120; v++) begin
      for (int h = 118; h < 242; h++) begin
        tft_de = 1'b1; hcnt = 10'(h); vcnt = 10'(v);
        e = (h >= 120 && h < 240) ? (v * 120 + h - 120) : int'(BG);
        q.push_back(e);
        #1;
        if ((v == 0 && (h == 120 || h == 239 || h == 240)) || (v == 1 && h == 120) ||
            (v == 119 && h == 239)) begin
          want = (h == 240) ? 119 : (v * 120 + h - 120);
          compared++;
          if (rom_addr !== 15'(want)) begin
            mismatched++;
            $display("FAIL rom_addr_%0d_%0d: got %0d want %0d", h, v, rom_addr, want);
          end
        end
        step();
        if (q.size() == 3) begin
          e = q.pop_front();
          compared++;
          if (data_in !== 16'(e)) begin
            mismatched++;
            $display("FAIL pixel_before_%0d_%0d: got %h want %h", h, v, data_in, 16'(e));
          end
        end
      end
    end
    tft_de = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q.push_back(int'(BG));
      step();
      e = q.pop_front();
      compared++;
      if (data_in !== 16'(e)) begin
        mismatched++;
        $display("FAIL pixel_flush_%0d: got %h want %h", i, data_in, 16'(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    // Position is (120,0) from the render test.
    mode = 2'd0;
    idle(6);
    do_frame();
    for (int h = 118; h <= 140; h++) begin
      tft_de = 1'b1; hcnt = 10'(h); vcnt = 10'd0;
      if (h < 140) step();
    end
    #1;
    compared++;
    if (data_in !== 16'd17) begin
      mismatched++;
      $display("FAIL pre_reset_pixel: got %h want %h", data_in, 16'd17);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (img_hbegin !== 10'd0 || img_vbegin !== 10'd0 || data_in !== BG || move_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: got pos=(%0d,%0d) data=%h ack=%b want pos=(0,0) data=%h ack=0",
               img_hbegin, img_vbegin, data_in, move_ack, BG);
    end
    step(); step();
    rst = 1'b0;
    tft_de = 1'b0;
    step();
    tft_de = 1'b1; hcnt = 10'd0; vcnt = 10'd0;
    #1;
    compared++;
    if (rom_addr !== 15'd0) begin
      mismatched++;
      $display("FAIL post_reset_addr0: got %0d want 0", rom_addr);
    end
    step();
    hcnt = 10'd1;
    #1;
    compared++;
    if (rom_addr !== 15'd1) begin
      mismatched++;
      $display("FAIL post_reset_addr1: got %0d want 1", rom_addr);
    end
    step();
    tft_de = 1'b0;
    step();
    compared++;
    if (data_in !== 16'd0) begin
      mismatched++;
      $display("FAIL post_reset_pix0: got %h want 0000", data_in);
    end
    step();
    compared++;
    if (data_in !== 16'd1) begin
      mismatched++;
      $display("FAIL post_reset_pix1: got %h want 0001", data_in);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tft_de = 1'b0; hcnt = 10'd0; vcnt = 10'd0; mode = 2'd0; pause = 1'b0;
    test_reset();
    test_tour();
    test_bounce();
    test_mode_switch();
    test_midframe_tick();
    test_back_to_back();
    test_pause();
    test_render();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
